// File: rtl/vertical_convolution.sv
// Vertical gradient stage: out(r,c) = clamp(p(r,c) - p(r-2,c)) using two line buffers.
// Reads from an upstream FIFO and writes to a downstream FIFO with a fixed 2-cycle latency.
module vertical_convolution #(
  parameter int          WIDTH        = 640,
  parameter int          HEIGHT       = 480,
  parameter logic [15:0] DELAY_CYCLES = 16'h00FF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_empty,
  output logic       read_request,
  input  logic [7:0] pixel_i,
  input  logic       out_full,
  output logic       write_request,
  output logic [7:0] pixel_o,
  output logic       finished,
  input  logic       sw
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int QW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {S_DELAY, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_reg;
  logic [15:0]     delay_count_reg;
  logic [QW-1:0]   req_count_reg;
  logic [CW-1:0]   col_reg;
  logic [RW-1:0]   row_reg;
  logic            accept_reg;
  logic            write_reg;
  logic [7:0]      pixel_o_reg;

  logic [7:0]      lb1_mem [WIDTH];
  logic [7:0]      lb2_mem [WIDTH];
  logic [7:0]      lb1_rd_reg;
  logic [7:0]      lb2_rd_reg;

  logic            col_last;
  logic            row_last;
  logic [CW-1:0]   col_next;
  logic [CW-1:0]   rd_addr;
  logic [8:0]      diff;
  logic [7:0]      result;

  assign read_request  = (state_reg == S_RUN) && !in_empty && !out_full &&
                         (req_count_reg < QW'(TOTAL));
  assign write_request = write_reg;
  assign pixel_o       = pixel_o_reg;
  assign finished      = (state_reg == S_DONE) && (delay_count_reg == DELAY_CYCLES);

  assign col_last = (col_reg == CW'(WIDTH - 1));
  assign row_last = (row_reg == RW'(HEIGHT - 1));
  assign col_next = col_last ? '0 : col_reg + CW'(1);

  // The buffer read is issued in the request cycle so its registered data lines up
  // with the accept cycle; if an accept is in progress the next pixel is one column on.
  assign rd_addr = accept_reg ? col_next : col_reg;

  always_ff @(posedge clk) begin
    lb1_rd_reg <= lb1_mem[rd_addr];
    lb2_rd_reg <= lb2_mem[rd_addr];
    if (accept_reg) begin
      lb1_mem[col_reg] <= pixel_i;
      lb2_mem[col_reg] <= lb1_rd_reg;
    end
  end

  always_comb begin
    diff   = {1'b0, pixel_i} - {1'b0, lb2_rd_reg};
    result = 8'd0;
    if (sw) begin
      result = pixel_i;
    end else if (row_reg >= RW'(2) && !diff[8]) begin
      result = diff[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_DELAY;
      delay_count_reg <= DELAY_CYCLES;
      req_count_reg   <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
      accept_reg      <= 1'b0;
      write_reg       <= 1'b0;
      pixel_o_reg     <= 8'd0;
    end else begin
      accept_reg <= read_request;
      write_reg  <= accept_reg;

      if (accept_reg) begin
        pixel_o_reg <= result;
        col_reg     <= col_next;
        if (col_last) begin
          row_reg <= row_last ? '0 : row_reg + RW'(1);
        end
      end

      case (state_reg)
        S_DELAY: begin
          if (delay_count_reg == 16'd0) state_reg <= S_RUN;
          else                          delay_count_reg <= delay_count_reg - 16'd1;
        end
        S_RUN: begin
          if (read_request) begin
            req_count_reg <= req_count_reg + QW'(1);
            if (req_count_reg == QW'(TOTAL - 1)) state_reg <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!accept_reg && !write_reg) state_reg <= S_DONE;
        end
        S_DONE: begin
          if (delay_count_reg != DELAY_CYCLES) delay_count_reg <= delay_count_reg + 16'd1;
        end
        default: state_reg <= S_DELAY;
      endcase
    end
  end

endmodule

// File: tb/tb_vertical_convolution.sv
// Bench for vertical_convolution on an 8x6 frame: FIFO model feeds pixels, a frame-level
// model predicts every output, and a single monitor checks values, latency and gating.
module tb_vertical_convolution;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clk;
  logic       reset;
  logic       in_empty;
  logic       read_request;
  logic [7:0] pixel_i;
  logic       out_full;
  logic       write_request;
  logic [7:0] pixel_o;
  logic       finished;
  logic       sw;

  vertical_convolution #(.WIDTH(W), .HEIGHT(H), .DELAY_CYCLES(16'd4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_empty      (in_empty),
    .read_request  (read_request),
    .pixel_i       (pixel_i),
    .out_full      (out_full),
    .write_request (write_request),
    .pixel_o       (pixel_o),
    .finished      (finished),
    .sw            (sw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  int img [N];
  int out_log [N];
  bit sw_f;
  bit loaded;
  bit alt_mode;

  // Monitor-owned state
  int cyc_rel, n_reads, n_writes, first_req, last_wr, first_fin, wr_full;
  bit fin_seen, pend;
  int req_q [$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected output for raster index k, straight from the gradient definition.
  function automatic int model(input int k);
    int r, d;
    r = k / W;
    if (sw_f) return img[k];
    if (r < 2) return 0;
    d = img[k] - img[k - 2 * W];
    return (d < 0) ? 0 : d;
  endfunction

  // Upstream FIFO: pops on the edge after a sampled request; empties after the frame.
  initial begin
    int rd_idx;
    bit tog;
    rd_idx   = 0;
    tog      = 1'b0;
    in_empty = 1'b1;
    pixel_i  = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        rd_idx = 0;
      end else if (pend) begin
        pixel_i = 8'(img[rd_idx]);
        rd_idx++;
      end
      tog      = ~tog;
      in_empty = !loaded || (rd_idx >= N) || (alt_mode && tog);
    end
  end

  // Single compare process
  always @(negedge clk) begin
    if (!reset) begin
      cyc_rel = 0; n_reads = 0; n_writes = 0; first_req = -1; last_wr = 0;
      first_fin = 0; wr_full = 0; fin_seen = 1'b0; pend = 1'b0;
      req_q.delete();
    end else begin
      cyc_rel++;
      pend = read_request;
      if (read_request) begin
        if (first_req < 0) first_req = cyc_rel;
        check("req_gate", int'(in_empty | out_full), 0);
        req_q.push_back(cyc_rel);
        n_reads++;
      end
      if (write_request) begin
        if (n_writes >= N || req_q.size() == 0) begin
          check("extra_write", n_writes, N - 1);
        end else begin
          check("latency", cyc_rel - req_q.pop_front(), 2);
          check("pixel", int'(pixel_o), model(n_writes));
          out_log[n_writes] = int'(pixel_o);
          $display("wr %0d (r%0d,c%0d) pixel_o=%0d model=%0d", n_writes,
                   n_writes / W, n_writes % W, pixel_o, model(n_writes));
        end
        if (out_full) wr_full++;
        n_writes++;
        last_wr = cyc_rel;
      end
      if (finished && !fin_seen) begin
        fin_seen  = 1'b1;
        first_fin = cyc_rel;
      end else if (fin_seen) begin
        check("finished_held", int'(finished), 1);
      end
    end
  end

  task automatic load(input int pat);
    for (int k = 0; k < N; k++) begin
      int r, c;
      r = k / W;
      c = k % W;
      case (pat)
        0:       img[k] = 10 * r;
        1:       img[k] = 200 - 30 * r;
        2:       img[k] = c * r;
        default: img[k] = 50;
      endcase
      out_log[k] = -1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_req"},   int'(read_request),  0);
    check({tag, "_wr_req"},   int'(write_request), 0);
    check({tag, "_pixel_o"},  int'(pixel_o),       0);
    check({tag, "_finished"}, int'(finished),      0);
  endtask

  // abort_at >= 0 pulls reset once that many reads have been seen.
  task automatic run_frame(input int pat, input bit sw_v, input bit alt,
                           input bit do_full, input int abort_at);
    int  full_left, cycles, after_fin, d;
    bit  full_done;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    out_full = 1'b0;
    #1;
    check_reset_outputs("reset");
    load(pat);
    sw_f     = sw_v;
    sw       = sw_v;
    alt_mode = alt;
    loaded   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b1;
    full_left = 0;
    full_done = 1'b0;
    after_fin = 0;
    for (cycles = 0; cycles < 1000; cycles++) begin
      @(posedge clk);
      #1;
      if (abort_at >= 0 && n_reads >= abort_at) begin
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) begin
          @(negedge clk);
          check("abort_no_write", int'(write_request), 0);
        end
        return;
      end
      if (do_full && !full_done && n_reads >= 3 * W + 3) begin
        out_full  = 1'b1;
        full_left = 10;
        full_done = 1'b1;
      end else if (full_left > 0) begin
        full_left--;
        if (full_left == 0) out_full = 1'b0;
      end
      if (fin_seen) after_fin++;
      if (after_fin >= 6) break;
    end
    check("frame_timeout", int'(cycles < 1000), 1);
    check("first_req_cycle", first_req, 6);
    check("read_count", n_reads, N);
    check("write_count", n_writes, N);
    if (do_full) begin
      n_checks++;
      if (wr_full > 2) begin
        n_fail++;
        $display("FAIL writes_after_full: got %0d expected at most 2", wr_full);
      end
    end
    d = first_fin - last_wr;
    n_checks++;
    if (!fin_seen || d < 5 || d > 10) begin
      n_fail++;
      $display("FAIL finished_delay: seen=%0d gap=%0d expected 5..10", fin_seen, d);
    end
  endtask

  initial begin
    reset    = 1'b0;
    out_full = 1'b0;
    sw       = 1'b0;
    sw_f     = 1'b0;
    loaded   = 1'b0;
    alt_mode = 1'b0;

    // Ramp 10*row: rows 0-1 give 0, later rows give 20
    run_frame(0, 1'b0, 1'b0, 1'b0, -1);
    check("ramp_r0c7", out_log[7], 0);
    check("ramp_r2c0", out_log[16], 20);
    check("ramp_r5c7", out_log[47], 20);

    // Descending frame: negative differences clamp to 0
    run_frame(1, 1'b0, 1'b0, 1'b0, -1);
    check("desc_r3c2", out_log[26], 0);
    check("desc_r5c7", out_log[47], 0);

    // Bypass: output equals input
    run_frame(1, 1'b1, 1'b0, 1'b0, -1);
    check("bypass_r0", out_log[0], 200);
    check("bypass_r1", out_log[8], 170);
    check("bypass_r5", out_log[40], 50);

    // Column-varying c*r: rows 2 and 5 give 2c
    run_frame(2, 1'b0, 1'b0, 1'b0, -1);
    check("cr_r2c7", out_log[23], 14);
    check("cr_r5c3", out_log[43], 6);
    check("cr_r5c7", out_log[47], 14);

    // Alternating empty plus a 10-cycle almost-full burst mid-row 3
    run_frame(0, 1'b0, 1'b1, 1'b1, -1);
    check("stall_r3c6", out_log[30], 20);
    check("stall_r4c1", out_log[33], 20);

    // Reset mid-row 4, then a clean constant frame: stale buffers never leak
    run_frame(0, 1'b0, 1'b0, 1'b0, 4 * W + 3);
    run_frame(3, 1'b0, 1'b0, 1'b0, -1);
    check("const_r2c0", out_log[16], 0);
    check("const_r5c7", out_log[47], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
